// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage and its helpers.
// Contents: datapath widths, the ALU NOP code, the ID/EX FSM state type, the packed
// ID/EX field bundle, the bubble constant and a helper that strips control bits.
package riscv_pipe_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = '0;

  typedef enum logic {
    StRun,
    StLoadStall
  } id_ex_state_t;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 rs1_valid;
    logic                 rs2_valid;
    logic                 write_enable;
    logic                 is_load;
    logic [XLEN-1:0]      operand1;
    logic [XLEN-1:0]      operand2;
    logic [XLEN-1:0]      imm;
    logic [ALU_OP_W-1:0]  alu_op;
  } id_ex_t;

  // Bubble field values: every control bit cleared, data fields zeroed.
  localparam logic BUBBLE_VALID        = 1'b0;
  localparam logic BUBBLE_RS1_VALID    = 1'b0;
  localparam logic BUBBLE_RS2_VALID    = 1'b0;
  localparam logic BUBBLE_WRITE_ENABLE = 1'b0;
  localparam logic BUBBLE_IS_LOAD      = 1'b0;

  localparam id_ex_t ID_EX_BUBBLE = '{
    valid:        BUBBLE_VALID,
    pc:           '0,
    rs1:          '0,
    rs2:          '0,
    rd:           '0,
    rs1_valid:    BUBBLE_RS1_VALID,
    rs2_valid:    BUBBLE_RS2_VALID,
    write_enable: BUBBLE_WRITE_ENABLE,
    is_load:      BUBBLE_IS_LOAD,
    operand1:     '0,
    operand2:     '0,
    imm:          '0,
    alu_op:       ALU_OP_NOP
  };

  // Keeps the data fields but makes the slot architecturally inert.
  function automatic id_ex_t kill_ctrl(input id_ex_t f);
    id_ex_t r;
    r              = f;
    r.valid        = BUBBLE_VALID;
    r.rs1_valid    = BUBBLE_RS1_VALID;
    r.rs2_valid    = BUBBLE_RS2_VALID;
    r.write_enable = BUBBLE_WRITE_ENABLE;
    r.is_load      = BUBBLE_IS_LOAD;
    return r;
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard compare.
// Ports:
//   ex_valid_i, ex_is_load_i, ex_write_enable_i, ex_rd_i : producer in EX
//   id_valid_i, id_rs1/rs2_i, id_rs1/rs2_valid_i       : consumer in ID
//   enable_i   : detection enabled (suppressed during the stall cycle)
//   hazard_o   : consumer needs the load result before it is forwardable
module load_use_detector
  import riscv_pipe_pkg::*;
(
  input  logic                 ex_valid_i,
  input  logic                 ex_is_load_i,
  input  logic                 ex_write_enable_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_rs1_valid_i,
  input  logic                 id_rs2_valid_i,
  input  logic                 enable_i,
  output logic                 hazard_o
);

  logic producer_live;
  logic src_match;

  always_comb begin
    // x0 is never a real destination, so it can never create a dependency.
    producer_live = ex_valid_i & ex_is_load_i & ex_write_enable_i & (ex_rd_i != '0);
    src_match     = (id_rs1_valid_i & (id_rs1_i == ex_rd_i)) |
                    (id_rs2_valid_i & (id_rs2_i == ex_rd_i));
    hazard_o      = enable_i & producer_live & id_valid_i & src_match;
  end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use bubble insertion, forwarding freeze and
// branch flush. Priority per edge: flush_in > freeze_in > hazard > normal load.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   id_*                : decoded fields and operands from Decode
//   freeze_in, flush_in : hold EX / squash EX
//   ex_*                : registered EX copies of the id_* fields
//   stall_id            : combinational hold request for IF/ID and PC
// Build option: ID_EX_STALL_CNT_EN adds saturating bubble_count / freeze_count outputs.
module id_ex_stage_register
  import riscv_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_rs1_valid,
  input  logic                 id_rs2_valid,
  input  logic                 id_write_enable,
  input  logic                 id_is_load,
  input  logic [XLEN-1:0]      id_operand1,
  input  logic [XLEN-1:0]      id_operand2,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [ALU_OP_W-1:0]  id_alu_op,
  input  logic                 freeze_in,
  input  logic                 flush_in,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic                 ex_rs1_valid,
  output logic                 ex_rs2_valid,
  output logic                 ex_write_enable,
  output logic                 ex_is_load,
  output logic [XLEN-1:0]      ex_operand1,
  output logic [XLEN-1:0]      ex_operand2,
  output logic [XLEN-1:0]      ex_imm,
  output logic [ALU_OP_W-1:0]  ex_alu_op,
  output logic                 stall_id
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]          bubble_count,
  output logic [31:0]          freeze_count
`endif
);

  id_ex_state_t state_q, state_d;
  id_ex_t       ex_q, ex_d;
  id_ex_t       id_fields;
  logic         hazard;
  logic         take_freeze;
  logic         take_hazard;

  always_comb begin
    id_fields = '{
      valid:        id_valid,
      pc:           id_pc,
      rs1:          id_rs1,
      rs2:          id_rs2,
      rd:           id_rd,
      rs1_valid:    id_rs1_valid,
      rs2_valid:    id_rs2_valid,
      write_enable: id_write_enable,
      is_load:      id_is_load,
      operand1:     id_operand1,
      operand2:     id_operand2,
      imm:          id_imm,
      alu_op:       id_alu_op
    };
  end

  // In StLoadStall the load has moved on to MEM, where forwarding can reach it.
  load_use_detector u_load_use_detector (
    .ex_valid_i        (ex_q.valid),
    .ex_is_load_i      (ex_q.is_load),
    .ex_write_enable_i (ex_q.write_enable),
    .ex_rd_i           (ex_q.rd),
    .id_valid_i        (id_valid),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_rs1_valid_i    (id_rs1_valid),
    .id_rs2_valid_i    (id_rs2_valid),
    .enable_i          (state_q == StRun),
    .hazard_o          (hazard)
  );

  always_comb begin
    take_freeze = ~flush_in & freeze_in;
    take_hazard = ~flush_in & ~freeze_in & hazard;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = StRun;
    end else if (freeze_in) begin
      state_d = state_q;
    end else if (hazard) begin
      state_d = StLoadStall;
    end else begin
      state_d = StRun;
    end
  end

  // Output logic; gated by rst so the hold request drops the moment reset hits.
  always_comb begin
    stall_id = ~rst & (take_freeze | take_hazard);
  end

  // EX field register.
  always_comb begin
    ex_d = ex_q;
    if (flush_in) begin
      ex_d = ID_EX_BUBBLE;
    end else if (freeze_in) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = ID_EX_BUBBLE;
    end else if (id_valid) begin
      ex_d = id_fields;
    end else begin
      ex_d = kill_ctrl(id_fields);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_comb begin
    ex_valid        = ex_q.valid;
    ex_pc           = ex_q.pc;
    ex_rs1          = ex_q.rs1;
    ex_rs2          = ex_q.rs2;
    ex_rd           = ex_q.rd;
    ex_rs1_valid    = ex_q.rs1_valid;
    ex_rs2_valid    = ex_q.rs2_valid;
    ex_write_enable = ex_q.write_enable;
    ex_is_load      = ex_q.is_load;
    ex_operand1     = ex_q.operand1;
    ex_operand2     = ex_q.operand2;
    ex_imm          = ex_q.imm;
    ex_alu_op       = ex_q.alu_op;
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] bubble_count_q, bubble_count_d;
  logic [31:0] freeze_count_q, freeze_count_d;

  always_comb begin
    bubble_count_d = bubble_count_q;
    freeze_count_d = freeze_count_q;
    if (take_hazard && (bubble_count_q != '1)) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end
    if (take_freeze && (freeze_count_q != '1)) begin
      freeze_count_d = freeze_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count_q <= '0;
      freeze_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
      freeze_count_q <= freeze_count_d;
    end
  end

  always_comb begin
    bubble_count = bubble_count_q;
    freeze_count = freeze_count_q;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Self-checking bench for id_ex_stage_register: directed scenarios followed by a
// randomized run, all compared against a reference model of the stage's rules.
// Honours ID_EX_STALL_CNT_EN when the counters are built in.
module tb_id_ex_stage_register;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1v;
    logic        rs2v;
    logic        we;
    logic        ld;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [3:0]  alu;
  } fields_t;

  logic    clk;
  logic    rst;
  logic    freeze_in;
  logic    flush_in;
  fields_t id_in;
  fields_t dut_ex;

  logic        ex_valid, ex_rs1_valid, ex_rs2_valid, ex_write_enable, ex_is_load;
  logic [31:0] ex_pc, ex_operand1, ex_operand2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        stall_id;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] bubble_count, freeze_count;
`endif

  int checks = 0;
  int failures = 0;
  int stall_seen = 0;

  // Reference model state.
  fields_t     exp_ex;
  bit          just_stalled;
  int unsigned exp_bubbles;
  int unsigned exp_freezes;

  id_ex_stage_register dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_in.valid),
    .id_pc           (id_in.pc),
    .id_rs1          (id_in.rs1),
    .id_rs2          (id_in.rs2),
    .id_rd           (id_in.rd),
    .id_rs1_valid    (id_in.rs1v),
    .id_rs2_valid    (id_in.rs2v),
    .id_write_enable (id_in.we),
    .id_is_load      (id_in.ld),
    .id_operand1     (id_in.op1),
    .id_operand2     (id_in.op2),
    .id_imm          (id_in.imm),
    .id_alu_op       (id_in.alu),
    .freeze_in       (freeze_in),
    .flush_in        (flush_in),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_rs1_valid    (ex_rs1_valid),
    .ex_rs2_valid    (ex_rs2_valid),
    .ex_write_enable (ex_write_enable),
    .ex_is_load      (ex_is_load),
    .ex_operand1     (ex_operand1),
    .ex_operand2     (ex_operand2),
    .ex_imm          (ex_imm),
    .ex_alu_op       (ex_alu_op),
    .stall_id        (stall_id)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .bubble_count    (bubble_count),
    .freeze_count    (freeze_count)
`endif
  );

  assign dut_ex = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_valid, ex_rs2_valid,
                   ex_write_enable, ex_is_load, ex_operand1, ex_operand2, ex_imm, ex_alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [151:0] obs, input logic [151:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_ex       = '0;
    just_stalled = 1'b0;
    exp_bubbles  = 0;
    exp_freezes  = 0;
  endtask

  // A consumer in ID needs a value that a load in EX has not produced yet; only one
  // bubble is ever owed for a given load.
  function automatic bit model_hazard();
    bit uses;
    uses = (id_in.rs1v && id_in.rs1 == exp_ex.rd) || (id_in.rs2v && id_in.rs2 == exp_ex.rd);
    return exp_ex.valid && exp_ex.ld && exp_ex.we && (exp_ex.rd != 5'd0) && id_in.valid
           && uses && !just_stalled;
  endfunction

  task automatic step(input string tag);
    bit hz;
    bit exp_stall;
    #1;
    hz        = model_hazard();
    exp_stall = !flush_in && (freeze_in || hz);
    check({tag, ":stall"}, 152'(stall_id), 152'(exp_stall));
    if (stall_id) stall_seen++;
    @(posedge clk);
    if (flush_in) begin
      exp_ex       = '0;
      just_stalled = 1'b0;
    end else if (freeze_in) begin
      if (exp_freezes != 32'hFFFF_FFFF) exp_freezes++;
    end else if (hz) begin
      exp_ex       = '0;
      just_stalled = 1'b1;
      if (exp_bubbles != 32'hFFFF_FFFF) exp_bubbles++;
    end else begin
      exp_ex       = id_in;
      just_stalled = 1'b0;
      if (!id_in.valid) begin
        exp_ex.rs1v = 1'b0;
        exp_ex.rs2v = 1'b0;
        exp_ex.we   = 1'b0;
        exp_ex.ld   = 1'b0;
      end
    end
    #1;
    check({tag, ":ex"}, dut_ex, exp_ex);
`ifdef ID_EX_STALL_CNT_EN
    check({tag, ":bubble_count"}, 152'(bubble_count), 152'(exp_bubbles));
    check({tag, ":freeze_count"}, 152'(freeze_count), 152'(exp_freezes));
`endif
  endtask

  task automatic set_instr(input bit v, input bit [4:0] rs1, input bit rs1v, input bit [4:0] rs2,
                           input bit rs2v, input bit [4:0] rd, input bit we, input bit ld);
    id_in.valid = v;
    id_in.pc    = $urandom;
    id_in.rs1   = rs1;
    id_in.rs1v  = rs1v;
    id_in.rs2   = rs2;
    id_in.rs2v  = rs2v;
    id_in.rd    = rd;
    id_in.we    = we;
    id_in.ld    = ld;
    id_in.op1   = $urandom;
    id_in.op2   = $urandom;
    id_in.imm   = $urandom;
    id_in.alu   = 4'($urandom_range(0, 15));
  endtask

  fields_t snap;

  initial begin
    rst       = 1'b1;
    freeze_in = 1'b0;
    flush_in  = 1'b0;
    id_in     = '0;
    model_reset();

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check("reset:ex", dut_ex, 152'(0));
    check("reset:stall", 152'(stall_id), 152'(0));
    #2 rst = 1'b0;

    // Normal flow.
    set_instr(1, 5'd5, 1, 5'd9, 1, 5'd2, 1, 0);
    id_in.op1 = 32'h1234;
    step("normal");
    check("normal:rs1", 152'(ex_rs1), 152'(5));
    check("normal:op1", 152'(ex_operand1), 152'(32'h1234));
    check("normal:valid", 152'(ex_valid), 152'(1));

    // Reset asserted mid-cycle while EX holds a valid instruction.
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("midreset:ex", dut_ex, 152'(0));
    check("midreset:stall", 152'(stall_id), 152'(0));
    #1 rst = 1'b0;

    // Load-use: load rd=7, then consumer reading rs2=7.
    set_instr(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 1);
    step("lu_load");
    set_instr(1, 5'd3, 0, 5'd7, 1, 5'd8, 1, 0);
    #1;
    check("lu:stall_hi", 152'(stall_id), 152'(1));
    step("lu_bubble");
    check("lu:bubble_valid", 152'(ex_valid), 152'(0));
    step("lu_enter");
    check("lu:enter_rs2", 152'(ex_rs2), 152'(7));
    check("lu:enter_valid", 152'(ex_valid), 152'(1));
`ifdef ID_EX_STALL_CNT_EN
    check("lu:bubble_count_1", 152'(bubble_count), 152'(1));
`endif

    // Flush and freeze together with a pending hazard: flush wins.
    set_instr(1, 5'd1, 1, 5'd2, 1, 5'd6, 1, 1);
    step("prio_load");
    set_instr(1, 5'd6, 1, 5'd0, 0, 5'd9, 1, 0);
    freeze_in = 1'b1;
    flush_in  = 1'b1;
    step("prio_both");
    check("prio:valid", 152'(ex_valid), 152'(0));
    flush_in = 1'b0;

    // Freeze for three cycles with changing ID contents.
    set_instr(1, 5'd4, 1, 5'd5, 1, 5'd10, 1, 0);
    freeze_in = 1'b0;
    step("frz_fill");
    snap      = dut_ex;
    freeze_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 5'($urandom_range(0, 31)), 1, 5'd1, 1, 5'd3, 1, 0);
      step("freeze");
    end
    check("freeze:held", dut_ex, snap);
    freeze_in = 1'b0;

    // Load to x0 followed by a reader of x0: never a hazard.
    set_instr(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 1);
    step("x0_load");
    set_instr(1, 5'd0, 1, 5'd0, 1, 5'd5, 1, 0);
    #1;
    check("x0:no_stall", 152'(stall_id), 152'(0));
    step("x0_use");

    // Dependent load chain: each link owes exactly one bubble.
    stall_seen = 0;
    set_instr(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1);
    step("chain_a");
    set_instr(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 1);
    step("chain_b_stall");
    step("chain_b_enter");
    set_instr(1, 5'd4, 1, 5'd0, 0, 5'd11, 1, 0);
    step("chain_c_stall");
    step("chain_c_enter");
    set_instr(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    step("chain_idle");
    check("chain:bubbles", 152'(stall_seen), 152'(2));

    // Randomized traffic with a small register range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      set_instr($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      flush_in  = ($urandom_range(0, 15) == 0);
      freeze_in = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
- ID/EX pipeline register that captures decoded fields and register-file operands from Decode.
- Presents them to Execute: the rs1/rs2 tags, validity bits and operands consumed by the operand forwarding logic.
- Owns load-use bubble insertion, honours the forwarding freeze, and squashes on branch flush.
- Drives stall_id back to the IF/ID register.

Parameters:
- XLEN, 32, data/PC width.
- ALU_OP_W, 4, ALU control field width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  Decode slot holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_valid, id_rs2_valid  in  1 each  source actually read.
- id_write_enable  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_operand1, id_operand2, id_imm  in  XLEN each  register-file reads and immediate.
- id_alu_op  in  ALU_OP_W  ALU control.
- freeze_in  in  1  Do_Freeze from the forwarding logic; hold EX.
- flush_in  in  1  taken branch/jump resolved in EX; squash.
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_valid, ex_rs2_valid, ex_write_enable, ex_is_load, ex_operand1, ex_operand2, ex_imm, ex_alu_op  out  widths as id_*  registered EX copies.
- stall_id  out  1  combinational; hold IF/ID and PC this cycle.

Behaviour:
- Reset (async, rst=1): all ex_* = 0, so EX holds a bubble. FSM = RUN. stall_id = 0.
- Bubble definition: ex_valid, ex_write_enable, ex_rs1_valid, ex_rs2_valid, ex_is_load = 0; all other ex_* = 0.
- Load-use hazard (combinational), true when all of the following hold:
  - ex_valid & ex_is_load & ex_write_enable & ex_rd != 0 & id_valid;
  - (id_rs1_valid & id_rs1 == ex_rd) | (id_rs2_valid & id_rs2 == ex_rd);
  - FSM == RUN.
- Per-edge priority: flush_in > freeze_in > hazard > normal load.
  - flush_in=1: EX loads a bubble; stall_id = 0; FSM -> RUN. Flush overrides a simultaneous freeze or hazard.
  - freeze_in=1 (no flush): all ex_* hold; stall_id = 1; FSM unchanged.
  - hazard (no flush/freeze): EX loads a bubble; stall_id = 1; FSM -> LOAD_STALL.
  - Normal: ex_* <= id_*; ex_valid <= id_valid; stall_id = 0.
  - If id_valid=0, control bits load as a bubble.
- FSM states:
  - RUN: hazard detection enabled.
  - LOAD_STALL: exactly one cycle. Hazard check suppressed, since the load has advanced to MEM and forwarding covers it. The held ID instruction loads normally. -> RUN.
  - freeze_in in LOAD_STALL holds both the state and ex_*.
- Latency: one cycle ID->EX. At most one bubble per load-use pair.
- Back-to-back loads that each depend on the previous load each insert exactly one bubble.
- x0: rd=0 never triggers a hazard.
- Reset mid-stall: immediate return to bubble/RUN; stall_id drops combinationally.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined: adds outputs bubble_count[31:0] and freeze_count[31:0].
  - bubble_count increments on each hazard bubble; freeze_count increments on each freeze_in cycle without flush.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: no counters and no ports. Behaviour is otherwise identical.

Decomposition:
- Package riscv_pipe_pkg: XLEN, ALU_OP_W, REG_IDX_W=5, ALU_OP_NOP, the id_ex_state_t enum (RUN, LOAD_STALL), and the bubble field constants.
- Sub-module load_use_detector: purely combinational hazard compare, reusable by later stages.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all ex_* = 0 immediately; stall_id = 0.
- Normal flow: id_valid=1, id_rs1=5, id_operand1=32'h1234 -> next cycle ex_rs1=5, ex_operand1=32'h1234; stall_id = 0.
- Load-use:
  - Stimulus: EX holds a load with rd=7; ID holds rs2=7, rs2_valid=1.
  - Response: stall_id=1 for one cycle and EX gets a bubble. Next cycle the ID instruction enters EX; stall_id=0.
  - With ID_EX_STALL_CNT_EN defined: bubble_count=1.
- Priority: freeze_in=1 and flush_in=1 together -> EX bubble, stall_id=0. freeze_in alone for 3 cycles -> ex_* unchanged, stall_id=1 throughout.
- Boundary:
  - Load with rd=0, consumer rs1=0 -> no stall.
  - Dependent load chain (rd=3 -> rs1=3, rd=4 -> rs1=4) -> exactly one bubble per pair.
